// File: rtl/bus_region_decoder.sv
// bus_region_decoder: decodes an address field to one of NS slaves, runs a registered
// request/ready handshake and returns data with a one-cycle ack, or err on unmapped/timeout.
module bus_region_decoder #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int NS       = 4,
    parameter int SEL_LO   = 7,
    parameter int SEL_BITS = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [DW-1:0]    rdata_o,
    output logic             ack_o,
    output logic             err_o,
    output logic             busy_o,
    output logic [NS-1:0]    s_sel_o,
    output logic             s_we_o,
    output logic [AW-1:0]    s_addr_o,
    output logic [DW-1:0]    s_wdata_o,
    input  logic [NS*DW-1:0] s_rdata_i,
    input  logic [NS-1:0]    s_ready_i
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;
    localparam logic [SEL_BITS:0] NS_W = (SEL_BITS+1)'(NS);

    logic [1:0]          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NS-1:0]       sel_q, sel_d, dec;
    logic                we_q, we_d, ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d, rdata_q, rdata_d, rd;
    logic [SEL_BITS-1:0] idx;
    logic                hit, rdy;

    always_comb begin
        idx = addr_i[SEL_LO +: SEL_BITS];
        hit = {1'b0, idx} < NS_W;
        rd  = '0;
        for (int i = 0; i < NS; i++) begin
            dec[i] = idx == SEL_BITS'(i);
            rd     = sel_q[i] ? s_rdata_i[i*DW +: DW] : rd;
        end
        // sel_q is one-hot in WAIT, so only the selected slave's ready counts
        rdy     = |(s_ready_i & sel_q);
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (req_i) begin
                we_d    = we_i;
                addr_d  = addr_i;
                wdata_d = wdata_i;
                cnt_d   = '0;
                sel_d   = hit ? dec : '0;
                state_d = hit ? WAIT : ERR;
            end
            WAIT: if (rdy) begin
                rdata_d = we_q ? rdata_q : rd;
                sel_d   = '0;
                we_d    = 1'b0;
                state_d = DONE;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                sel_d   = '0;
                we_d    = 1'b0;
                state_d = ERR;
            end else begin
                cnt_d = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
            end
            DONE: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ack_d   = 1'b1;
                err_d   = 1'b1;
                we_d    = 1'b0;
                rdata_d = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;
    assign s_sel_o   = sel_q;
    assign s_we_o    = we_q;
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;
endmodule
